// File: rtl/axi_lite_reg_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to register-strobe bridge.
package axi_lite_reg_bridge_pkg;

  // One state per phase of the single outstanding transaction.
  typedef enum logic [2:0] {
    IDLE,
    W_DATA,
    W_USER,
    W_RESP,
    R_REQ,
    R_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave that presents one write or read at a time to user logic
// through a level request / single-cycle strobe register interface.
// Optional build macro AXI_LITE_TIMEOUT_EN adds a user-logic response timeout
// of TIMEOUT_CYCLES cycles that completes the transaction with SLVERR.
module axi_lite_reg_bridge
  import axi_lite_reg_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic [1:0]            o_bresp,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic [1:0]            o_rresp,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [ADDR_WIDTH-1:0] o_reg_address,
  input  logic                  i_reg_invalid_addr,
  output logic                  o_reg_in_rdy,
  input  logic                  i_reg_in_ack_stb,
  output logic [DATA_WIDTH-1:0] o_reg_in_data,
  output logic                  o_reg_out_req,
  input  logic                  i_reg_out_rdy_stb,
  input  logic [DATA_WIDTH-1:0] i_reg_out_data
);

  state_t state, state_next;
  logic   tmo_hit;

`ifdef AXI_LITE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Count cycles spent waiting on user logic; cleared in every other state so
  // each wait starts from zero.
  always_ff @(posedge clk) begin
    if (rst)
      tmo_cnt <= '0;
    else if (state == W_USER || state == R_REQ)
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    else
      tmo_cnt <= '0;
  end

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; write wins when aw and ar arrive together.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next
    // unassigned, which would infer a latch.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (i_awvalid)      state_next = W_DATA;
        else if (i_arvalid) state_next = R_REQ;
      end
      W_DATA: if (i_wvalid)                      state_next = W_USER;
      W_USER: if (i_reg_in_ack_stb || tmo_hit)   state_next = W_RESP;
      W_RESP: if (i_bready)                      state_next = IDLE;
      R_REQ:  if (i_reg_out_rdy_stb || tmo_hit)  state_next = R_RESP;
      R_RESP: if (i_rready)                      state_next = IDLE;
      default:                                   state_next = IDLE;
    endcase
  end

  // Handshake and request levels are pure state decodes.
  assign o_awready     = (state == IDLE);
  assign o_arready     = (state == IDLE);
  assign o_wready      = (state == W_DATA);
  assign o_reg_in_rdy  = (state == W_USER);
  assign o_bvalid      = (state == W_RESP);
  assign o_reg_out_req = (state == R_REQ);
  assign o_rvalid      = (state == R_RESP);

  // Datapath capture: address, write data, read data and responses hold
  // until the next transaction overwrites them.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_reg_address <= '0;
      o_reg_in_data <= '0;
      o_rdata       <= '0;
      o_bresp       <= RESP_OKAY;
      o_rresp       <= RESP_OKAY;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_awvalid)      o_reg_address <= i_awaddr;
          else if (i_arvalid) o_reg_address <= i_araddr;
        end
        W_DATA: if (i_wvalid) o_reg_in_data <= i_wdata;
        W_USER: begin
          if (i_reg_in_ack_stb)
            o_bresp <= i_reg_invalid_addr ? RESP_SLVERR : RESP_OKAY;
          else if (tmo_hit)
            o_bresp <= RESP_SLVERR;
        end
        R_REQ: begin
          if (i_reg_out_rdy_stb) begin
            o_rdata <= i_reg_out_data;
            o_rresp <= i_reg_invalid_addr ? RESP_SLVERR : RESP_OKAY;
          end else if (tmo_hit) begin
            o_rdata <= '0;
            o_rresp <= RESP_SLVERR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Self-checking bench for axi_lite_reg_bridge: directed table, randomized
// transactions against a register-file model, and multi-cycle corner cases.
module tb_axi_lite_reg_bridge;

`ifdef AXI_LITE_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_awvalid, o_awready;
  logic [15:0] i_awaddr;
  logic        i_wvalid, o_wready;
  logic [31:0] i_wdata;
  logic        o_bvalid, i_bready;
  logic [1:0]  o_bresp;
  logic        i_arvalid, o_arready;
  logic [15:0] i_araddr;
  logic        o_rvalid, i_rready;
  logic [1:0]  o_rresp;
  logic [31:0] o_rdata;
  logic [15:0] o_reg_address;
  logic        i_reg_invalid_addr;
  logic        o_reg_in_rdy, i_reg_in_ack_stb;
  logic [31:0] o_reg_in_data;
  logic        o_reg_out_req, i_reg_out_rdy_stb;
  logic [31:0] i_reg_out_data;

  axi_lite_reg_bridge #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rresp(o_rresp), .o_rdata(o_rdata),
    .o_reg_address(o_reg_address), .i_reg_invalid_addr(i_reg_invalid_addr),
    .o_reg_in_rdy(o_reg_in_rdy), .i_reg_in_ack_stb(i_reg_in_ack_stb),
    .o_reg_in_data(o_reg_in_data), .o_reg_out_req(o_reg_out_req),
    .i_reg_out_rdy_stb(i_reg_out_rdy_stb), .i_reg_out_data(i_reg_out_data)
  );

  always #5 clk = ~clk;

  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  int checks = 0;
  int errors = 0;

  // Register-file model of the user logic: 16 words at 0x00..0x3C;
  // addresses 0x40 and up are invalid and return JUNK with SLVERR.
  logic [31:0] mem [16];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic        inv;
    int          dly;
    int          hold;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic inv, input int dly, input int hold,
                           output logic [1:0] resp);
    i_awvalid = 1'b1; i_awaddr = addr; i_wvalid = 1'b1; i_wdata = data;
    for (int n = 0; n < 20 && !o_awready; n++) @(negedge clk);
    check("wr_awready", o_awready, 1);
    @(negedge clk);
    i_awvalid = 1'b0;
    check("wr_awready_drop", o_awready, 0);
    for (int n = 0; n < 20 && !o_wready; n++) @(negedge clk);
    check("wr_wready", o_wready, 1);
    @(negedge clk);
    i_wvalid = 1'b0;
    check("wr_in_rdy", o_reg_in_rdy, 1);
    check("wr_address", o_reg_address, addr);
    check("wr_in_data", o_reg_in_data, data);
    repeat (dly) @(negedge clk);
    check("wr_in_rdy_hold", o_reg_in_rdy, 1);
    i_reg_in_ack_stb = 1'b1; i_reg_invalid_addr = inv;
    @(negedge clk);
    i_reg_in_ack_stb = 1'b0; i_reg_invalid_addr = 1'b0;
    check("wr_in_rdy_drop", o_reg_in_rdy, 0);
    check("wr_bvalid", o_bvalid, 1);
    resp = o_bresp;
    repeat (hold) @(negedge clk);
    check("wr_bvalid_hold", o_bvalid, 1);
    check("wr_bresp_hold", o_bresp, resp);
    i_bready = 1'b1;
    @(negedge clk);
    i_bready = 1'b0;
    check("wr_bvalid_drop", o_bvalid, 0);
  endtask

  task automatic axi_read(input logic [15:0] addr, input logic [31:0] user_data,
                          input logic inv, input int dly, input int hold,
                          output logic [1:0] resp, output logic [31:0] rdata);
    i_arvalid = 1'b1; i_araddr = addr;
    for (int n = 0; n < 20 && !o_arready; n++) @(negedge clk);
    check("rd_arready", o_arready, 1);
    @(negedge clk);
    i_arvalid = 1'b0;
    check("rd_out_req", o_reg_out_req, 1);
    check("rd_address", o_reg_address, addr);
    repeat (dly) @(negedge clk);
    check("rd_out_req_hold", o_reg_out_req, 1);
    i_reg_out_rdy_stb = 1'b1; i_reg_out_data = user_data; i_reg_invalid_addr = inv;
    @(negedge clk);
    i_reg_out_rdy_stb = 1'b0; i_reg_out_data = '0; i_reg_invalid_addr = 1'b0;
    check("rd_out_req_drop", o_reg_out_req, 0);
    check("rd_rvalid", o_rvalid, 1);
    resp = o_rresp; rdata = o_rdata;
    repeat (hold) @(negedge clk);
    check("rd_rvalid_hold", o_rvalid, 1);
    check("rd_rdata_hold", o_rdata, rdata);
    i_rready = 1'b1;
    @(negedge clk);
    i_rready = 1'b0;
    check("rd_rvalid_drop", o_rvalid, 0);
  endtask

  // Apply one transaction, updating the model; returns observed values.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                         input logic inv, input int dly, input int hold,
                         output logic [1:0] resp, output logic [31:0] rdata);
    rdata = '0;
    if (wr) begin
      axi_write(addr, data, inv, dly, hold, resp);
      if (!inv) mem[addr[5:2]] = data;
    end else begin
      axi_read(addr, inv ? JUNK : mem[addr[5:2]], inv, dly, hold, resp, rdata);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata, exp_rd;
    logic [15:0] addr;
    logic        wr, inv;
    logic [31:0] data;
    int          n;

    rst = 1'b1;
    i_awvalid = 0; i_awaddr = '0; i_wvalid = 0; i_wdata = '0; i_bready = 0;
    i_arvalid = 0; i_araddr = '0; i_rready = 0; i_reg_invalid_addr = 0;
    i_reg_in_ack_stb = 0; i_reg_out_rdy_stb = 0; i_reg_out_data = '0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[3] = 32'h1000_0000;
    mem[4] = 32'h0CA7_CAFE;
    mem[7] = 32'h7777_7777;

    vecs[0] = '{1'b1, 16'h0008, 32'h0000_0FA0, 1'b0, 1, 0, OKAY,   32'h0};
    vecs[1] = '{1'b0, 16'h000C, 32'h0,         1'b0, 2, 1, OKAY,   32'h1000_0000};
    vecs[2] = '{1'b1, 16'h001C, 32'h0000_1234, 1'b1, 0, 0, SLVERR, 32'h0};
    vecs[3] = '{1'b0, 16'h0010, 32'h0,         1'b0, 0, 0, OKAY,   32'h0CA7_CAFE};
    vecs[4] = '{1'b0, 16'h0008, 32'h0,         1'b0, 1, 2, OKAY,   32'h0000_0FA0};
    vecs[5] = '{1'b0, 16'h001C, 32'h0,         1'b0, 3, 0, OKAY,   32'h7777_7777};
    vecs[6] = '{1'b0, 16'h0050, 32'h0,         1'b1, 1, 1, SLVERR, JUNK};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_bvalid", o_bvalid, 0);
    check("rst_rvalid", o_rvalid, 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_address", o_reg_address, 0);
    check("rst_in_rdy", o_reg_in_rdy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", o_awready, 1);
    check("idle_arready", o_arready, 1);

    // Directed table.
    foreach (vecs[i]) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].inv,
              vecs[i].dly, vecs[i].hold, resp, rdata);
      check($sformatf("vec%0d_resp", i), resp, vecs[i].exp_resp);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
    end

    // Randomized transactions against the register-file model.
    for (int i = 0; i < 24; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 16'($urandom_range(0, 31) * 4);
      inv  = (addr >= 16'h0040);
      data = $urandom;
      exp_rd = inv ? JUNK : mem[addr[5:2]];
      run_txn(wr, addr, data, inv, $urandom_range(0, 4), $urandom_range(0, 3), resp, rdata);
      check($sformatf("rnd%0d_resp", i), resp, inv ? SLVERR : OKAY);
      if (!wr) check($sformatf("rnd%0d_rdata", i), rdata, exp_rd);
    end

    // Simultaneous aw/ar: write first, read accepted after bready; bready low 5 cycles.
    i_awvalid = 1; i_awaddr = 16'h0020; i_arvalid = 1; i_araddr = 16'h0024;
    i_wvalid = 1; i_wdata = 32'h0000_ABCD;
    for (n = 0; n < 20 && !o_awready; n++) @(negedge clk);
    @(negedge clk);
    i_awvalid = 0;
    check("both_arready_low", o_arready, 0);
    check("both_address_wr", o_reg_address, 16'h0020);
    @(negedge clk);
    i_wvalid = 0;
    check("both_in_rdy", o_reg_in_rdy, 1);
    i_reg_in_ack_stb = 1;
    @(negedge clk);
    i_reg_in_ack_stb = 0;
    mem[8] = 32'h0000_ABCD;
    for (int k = 0; k < 5; k++) begin
      check("both_bvalid_stable", o_bvalid, 1);
      check("both_bresp_stable", o_bresp, OKAY);
      check("both_no_read", o_reg_out_req, 0);
      @(negedge clk);
    end
    i_bready = 1;
    @(negedge clk);
    i_bready = 0;
    check("both_arready_idle", o_arready, 1);
    @(negedge clk);
    i_arvalid = 0;
    check("both_out_req", o_reg_out_req, 1);
    check("both_address_rd", o_reg_address, 16'h0024);
    i_reg_out_rdy_stb = 1; i_reg_out_data = mem[9];
    @(negedge clk);
    i_reg_out_rdy_stb = 0;
    check("both_rvalid", o_rvalid, 1);
    check("both_rdata", o_rdata, mem[9]);
    check("both_rresp", o_rresp, OKAY);
    i_rready = 1;
    @(negedge clk);
    i_rready = 0;

    // Reset asserted while waiting in W_USER drops the write.
    i_awvalid = 1; i_awaddr = 16'h0030; i_wvalid = 1; i_wdata = 32'h5555_AAAA;
    for (n = 0; n < 20 && !o_awready; n++) @(negedge clk);
    @(negedge clk);
    i_awvalid = 0;
    @(negedge clk);
    i_wvalid = 0;
    check("mid_in_rdy", o_reg_in_rdy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid_in_rdy0", o_reg_in_rdy, 0);
    check("mid_address0", o_reg_address, 0);
    check("mid_in_data0", o_reg_in_data, 0);
    check("mid_rdata0", o_rdata, 0);
    check("mid_bvalid0", o_bvalid, 0);
    check("mid_wready0", o_wready, 0);
    check("mid_awready1", o_awready, 1);
    check("mid_arready1", o_arready, 1);
    i_reg_in_ack_stb = 1; i_reg_out_rdy_stb = 1;
    @(negedge clk);
    i_reg_in_ack_stb = 0; i_reg_out_rdy_stb = 0;
    repeat (3) @(negedge clk);
    check("mid_no_bvalid", o_bvalid, 0);
    check("mid_no_rvalid", o_rvalid, 0);
    check("mid_idle", o_awready, 1);
    run_txn(1'b0, 16'h0030, 32'h0, 1'b0, 0, 0, resp, rdata);
    check("mid_dropped_write", rdata, mem[12]);

`ifdef AXI_LITE_TIMEOUT_EN
    // Read that user logic never answers: SLVERR with zero data after TMO cycles.
    i_arvalid = 1; i_araddr = 16'h0004;
    for (n = 0; n < 20 && !o_arready; n++) @(negedge clk);
    @(negedge clk);
    i_arvalid = 0;
    n = 0;
    while (!o_rvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, TMO);
    check("tmo_rresp", o_rresp, SLVERR);
    check("tmo_rdata", o_rdata, 0);
    check("tmo_out_req", o_reg_out_req, 0);
    i_rready = 1;
    @(negedge clk);
    i_rready = 0;
    check("tmo_idle", o_arready, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
